// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies the raw PLL lock, then releases NUM_RESETS
// active-high domain resets one at a time (bit 0 first) with STAGE_GAP cycles
// between releases. Lock loss or a soft reset request reasserts everything.
// Optional watchdog that pulses pll_resetb low: define PLL_RESET_WATCHDOG_EN.
module pll_reset_sequencer #(
  parameter int NUM_RESETS         = 4,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int LOSS_COUNT_WIDTH   = 8,
  parameter int WATCHDOG_BITS      = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pll_locked,
  input  logic                        soft_reset_req,
  output logic [NUM_RESETS-1:0]       resets_out,
  output logic                        all_released,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count,
  output logic [1:0]                  seq_state,
  output logic                        pll_resetb
);

  localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int STG_W  = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_RESETS - 1);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_chk_stable
    $error("LOCK_STABLE_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_chk_gap
    $error("STAGE_GAP must be >= 1");
  end
  if (WATCHDOG_BITS < 1) begin : g_chk_wd
    $error("WATCHDOG_BITS must be >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        lock_s;
  logic [STAB_W-1:0]           stable_q, stable_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [STG_W-1:0]            stage_q, stage_d;
  logic [NUM_RESETS-1:0]       resets_q, resets_d;
  logic                        all_rel_q, all_rel_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;
  logic                        wd_hold;

  // Synchronise the asynchronous lock indication into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Sequencer state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      stable_q  <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      resets_q  <= '1;
      all_rel_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      resets_q  <= resets_d;
      all_rel_q <= all_rel_d;
      loss_q    <= loss_d;
    end
  end

  // Next-state logic: lock qualification, staged release, lock-loss/soft-reset handling.
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    gap_d     = gap_q;
    stage_d   = stage_q;
    resets_d  = resets_q;
    all_rel_d = all_rel_q;
    loss_d    = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d  = STABILISE;
          stable_d = '0;
        end
      end
      STABILISE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stable_q == STAB_LAST) begin
          state_d = RELEASE;
          gap_d   = '0;
          stage_d = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          // Lock loss has priority over a concurrent soft reset request.
          state_d   = WAIT_LOCK;
          resets_d  = '1;
          all_rel_d = 1'b0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (soft_reset_req) begin
          state_d   = RELEASE;
          gap_d     = '0;
          stage_d   = '0;
          resets_d  = '1;
          all_rel_d = 1'b0;
        end else if (state_q == RELEASE) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            stage_d = stage_q + 1'b1;
            for (int i = 0; i < NUM_RESETS; i++) begin
              if (STG_W'(i) == stage_q) resets_d[i] = 1'b0;
            end
            if (stage_q == STG_LAST) begin
              state_d   = RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
    endcase
    // A watchdog pulse only occurs before release, so holding WAIT_LOCK is safe.
    if (wd_hold) state_d = WAIT_LOCK;
  end

`ifdef PLL_RESET_WATCHDOG_EN
  logic [WATCHDOG_BITS-1:0] wd_q, wd_d;
  logic                     wd_pulse_q, wd_pulse_d;
  logic [3:0]               wd_pcnt_q, wd_pcnt_d;

  // Watchdog timer and 16-cycle pll_resetb pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q       <= '0;
      wd_pulse_q <= 1'b0;
      wd_pcnt_q  <= '0;
    end else begin
      wd_q       <= wd_d;
      wd_pulse_q <= wd_pulse_d;
      wd_pcnt_q  <= wd_pcnt_d;
    end
  end

  // Timer runs only while waiting for lock; wrap fires the pulse, timer frozen at 0 during it.
  always_comb begin
    wd_d       = wd_q;
    wd_pulse_d = wd_pulse_q;
    wd_pcnt_d  = wd_pcnt_q;
    if (wd_pulse_q) begin
      wd_d      = '0;
      wd_pcnt_d = wd_pcnt_q + 4'd1;
      if (wd_pcnt_q == 4'd15) wd_pulse_d = 1'b0;
    end else if (state_d == RELEASE || state_d == RUN) begin
      wd_d = '0;
    end else if (wd_q == '1) begin
      wd_d       = '0;
      wd_pulse_d = 1'b1;
      wd_pcnt_d  = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_hold    = wd_pulse_q;
  assign pll_resetb = ~wd_pulse_q;
`else
  assign wd_hold    = 1'b0;
  assign pll_resetb = 1'b1;
`endif

  assign resets_out      = resets_q;
  assign all_released    = all_rel_q;
  assign lock_loss_count = loss_q;
  assign seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with NUM_RESETS=3, LOCK_STABLE_CYCLES=8,
// STAGE_GAP=4, SYNC_STAGES=2, WATCHDOG_BITS=6. Edge 1 is the first rising edge
// after reset deassertion with pll_locked already high.
module tb_pll_reset_sequencer;

  localparam int NR  = 3;
  localparam int LCW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           pll_locked;
  logic           soft_reset_req;
  logic [NR-1:0]  resets_out;
  logic           all_released;
  logic [LCW-1:0] lock_loss_count;
  logic [1:0]     seq_state;
  logic           pll_resetb;

  int n_chk  = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .NUM_RESETS(NR),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP(4),
    .SYNC_STAGES(2),
    .LOSS_COUNT_WIDTH(LCW),
    .WATCHDOG_BITS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .soft_reset_req(soft_reset_req),
    .resets_out(resets_out),
    .all_released(all_released),
    .lock_loss_count(lock_loss_count),
    .seq_state(seq_state),
    .pll_resetb(pll_resetb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    step(2);
    chk("rst_resets", resets_out, 3'b111);
    chk("rst_allrel", all_released, 1'b0);
    chk("rst_count", lock_loss_count, 0);
    chk("rst_state", seq_state, 0);
    chk("rst_resetb", pll_resetb, 1'b1);

    // Cold start
    reset      = 1'b0;
    pll_locked = 1'b1;
    step(2);  chk("cold_e2_state", seq_state, 0);
    step(1);  chk("cold_e3_state", seq_state, 1);
    step(7);  chk("cold_e10_state", seq_state, 1);
    step(1);  chk("cold_e11_state", seq_state, 2);
              chk("cold_e11_resets", resets_out, 3'b111);
    step(3);  chk("cold_e14_resets", resets_out, 3'b111);
    step(1);  chk("cold_e15_resets", resets_out, 3'b110);
    step(3);  chk("cold_e18_resets", resets_out, 3'b110);
    step(1);  chk("cold_e19_resets", resets_out, 3'b100);
              chk("cold_e19_allrel", all_released, 1'b0);
    step(4);  chk("cold_e23_resets", resets_out, 3'b000);
              chk("cold_e23_allrel", all_released, 1'b1);
              chk("cold_e23_state", seq_state, 3);
    step(5);  chk("run_hold_resets", resets_out, 3'b000);

    // Lock loss in RUN: two edges through the synchroniser, third edge reacts
    pll_locked = 1'b0;
    step(2);  chk("loss_e2_state", seq_state, 3);
              chk("loss_e2_resets", resets_out, 3'b000);
    step(1);  chk("loss_e3_state", seq_state, 0);
              chk("loss_e3_resets", resets_out, 3'b111);
              chk("loss_e3_allrel", all_released, 1'b0);
              chk("loss_e3_count", lock_loss_count, 1);

    // Lock bounce in STABILISE
    pll_locked = 1'b1;
    step(3);  chk("bounce_stab", seq_state, 1);
    step(2);
    pll_locked = 1'b0;
    step(3);  chk("bounce_state", seq_state, 0);
              chk("bounce_resets", resets_out, 3'b111);
              chk("bounce_count", lock_loss_count, 1);
    pll_locked = 1'b1;
    step(2);  chk("bounce_e10_state", seq_state, 0);
    step(1);  chk("bounce_e11_state", seq_state, 1);
    step(7);  chk("bounce_e18_state", seq_state, 1);
    step(1);  chk("bounce_e19_state", seq_state, 2);

    // Soft reset mid-RELEASE
    step(4);  chk("soft_pre_resets", resets_out, 3'b110);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
              chk("soft_resets", resets_out, 3'b111);
              chk("soft_state", seq_state, 2);
    step(3);  chk("soft_e3_resets", resets_out, 3'b111);
    step(1);  chk("soft_e4_resets", resets_out, 3'b110);
              chk("soft_count", lock_loss_count, 1);
    step(8);  chk("soft_run_state", seq_state, 3);
              chk("soft_run_resets", resets_out, 3'b000);

    // Soft reset in RUN restarts RELEASE without STABILISE
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
              chk("softrun_state", seq_state, 2);
              chk("softrun_resets", resets_out, 3'b111);
              chk("softrun_allrel", all_released, 1'b0);
    step(12); chk("softrun_done_state", seq_state, 3);
              chk("softrun_done_resets", resets_out, 3'b000);

    // Simultaneous lock_s fall and soft_reset_req in RUN
    pll_locked = 1'b0;
    step(2);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
              chk("simul_state", seq_state, 0);
              chk("simul_count", lock_loss_count, 2);
              chk("simul_resets", resets_out, 3'b111);

    // soft_reset_req ignored in WAIT_LOCK
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
              chk("soft_wait_state", seq_state, 0);
    step(1);  chk("soft_wait_state2", seq_state, 0);

    // Asynchronous reset mid-sequence, applied away from any clock edge
    pll_locked = 1'b1;
    step(12); chk("async_pre_state", seq_state, 2);
    #3;
    reset = 1'b1;
    #1;       chk("async_state", seq_state, 0);
              chk("async_count", lock_loss_count, 0);
              chk("async_resets", resets_out, 3'b111);
    step(1);
    reset = 1'b0;

    // Lock-loss counter saturation
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b1;
      step(11);
      if (i == 0) chk("sat_first_state", seq_state, 2);
      pll_locked = 1'b0;
      step(3);
      if (i == 0)   chk("sat_first_count", lock_loss_count, 1);
      if (i == 254) chk("sat_255_count", lock_loss_count, 255);
    end
    chk("sat_final_count", lock_loss_count, 255);
    chk("sat_final_state", seq_state, 0);

`ifdef PLL_RESET_WATCHDOG_EN
    // Watchdog pulse with pll_locked held low
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(63); chk("wd_e63", pll_resetb, 1'b1);
    step(1);  chk("wd_e64", pll_resetb, 1'b0);
              chk("wd_e64_state", seq_state, 0);
    step(15); chk("wd_e79", pll_resetb, 1'b0);
    step(1);  chk("wd_e80", pll_resetb, 1'b1);
    step(63); chk("wd_e143", pll_resetb, 1'b1);
    step(1);  chk("wd_e144", pll_resetb, 1'b0);
    step(16); chk("wd_e160", pll_resetb, 1'b1);
`else
    step(100);
    chk("no_wd_resetb", pll_resetb, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
